alu_ctrl_sequencer: RTL and testbench

- Multi-cycle control unit and ALU initiator for the 8-bit RISC core.
- Fetches 16-bit instructions and decodes them.
- Drives the ALU opcode/enable interface and consumes the ALU compare output.
- Sequences register-file and data-memory strobes; owns the PC and the compare flag used for conditional branches.

---
 rtl/cpu_ctrl_pkg.sv | 37 +++
 rtl/ctrl_decode.sv | 28 ++
 rtl/alu_ctrl_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_ctrl_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, FSM state encodings and instruction field positions for the
// 8-bit RISC control sequencer.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_CMP   = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'h6;
    localparam logic [3:0] OP_STORE = 4'h7;
    localparam logic [3:0] OP_BEQ   = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int RT_MSB  = 7;
    localparam int RT_LSB  = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier feeding the sequencer FSM; purely combinational, zero latency,
// no flow control.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] i_op,
    output logic       o_uses_alu,
    output logic       o_uses_mem,
    output logic       o_is_load,
    output logic       o_is_store,
    output logic       o_is_branch,
    output logic       o_is_jump,
    output logic       o_is_halt,
    output logic       o_writes_rd
);

    always_comb begin
        o_uses_alu  = (i_op <= OP_STORE);
        o_is_load   = (i_op == OP_LOAD);
        o_is_store  = (i_op == OP_STORE);
        o_uses_mem  = o_is_load || o_is_store;
        o_is_branch = (i_op == OP_BEQ);
        o_is_jump   = (i_op == OP_JMP);
        o_is_halt   = (i_op == OP_HALT);
        o_writes_rd = (i_op <= OP_XOR) || o_is_load;
    end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving ALU, register file and data memory.
// Latency 3-5 cycles per instruction; no backpressure, HALT is absorbing until reset.
module alu_ctrl_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [3:0]         alu_opcode,
    output logic               alu_src,
    input  logic               alu_compare,
    output logic               alu_b_sel,
    output logic [7:0]         imm,
    output logic [1:0]         rf_ra1,
    output logic [1:0]         rf_ra2,
    output logic [1:0]         rf_wa,
    output logic               rf_we,
    output logic               rf_wsel,
    output logic               dmem_re,
    output logic               dmem_we,
    output logic               halted
);

    state_t               r_state, w_state_nxt;
    logic [PC_W-1:0]      r_pc, w_pc_nxt;
    logic [INSTR_W-1:0]   r_ir, w_ir_nxt;
    logic                 r_cmp_flag, w_cmp_flag_nxt;

    logic [3:0] w_op;
    logic       w_uses_alu, w_uses_mem, w_is_load, w_is_store;
    logic       w_is_branch, w_is_jump, w_is_halt, w_writes_rd;

    assign w_op = r_ir[OP_MSB:OP_LSB];

    ctrl_decode u_decode (
        .i_op        (w_op),
        .o_uses_alu  (w_uses_alu),
        .o_uses_mem  (w_uses_mem),
        .o_is_load   (w_is_load),
        .o_is_store  (w_is_store),
        .o_is_branch (w_is_branch),
        .o_is_jump   (w_is_jump),
        .o_is_halt   (w_is_halt),
        .o_writes_rd (w_writes_rd)
    );

    // Register addresses and immediate are plain field taps of the latched instruction.
    assign imem_addr = r_pc;
    assign imm       = r_ir[IMM_MSB:IMM_LSB];
    assign rf_ra1    = r_ir[RS_MSB:RS_LSB];
    assign rf_ra2    = w_is_store ? r_ir[RD_MSB:RD_LSB] : r_ir[RT_MSB:RT_LSB];
    assign rf_wa     = r_ir[RD_MSB:RD_LSB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FETCH;
            r_pc       <= '0;
            r_ir       <= '0;
            r_cmp_flag <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_cmp_flag <= w_cmp_flag_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_ir_nxt       = r_ir;
        w_cmp_flag_nxt = r_cmp_flag;
        alu_src        = 1'b0;
        alu_opcode     = 4'h0;
        alu_b_sel      = 1'b0;
        rf_we          = 1'b0;
        rf_wsel        = 1'b0;
        dmem_re        = 1'b0;
        dmem_we        = 1'b0;
        halted         = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                w_ir_nxt    = imem_data;
                w_pc_nxt    = r_pc + 1'b1;
                w_state_nxt = (imem_data[OP_MSB:OP_LSB] == OP_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                alu_src     = 1'b1;
                alu_opcode  = w_uses_alu ? w_op : 4'h0;
                alu_b_sel   = w_uses_mem;
                w_state_nxt = ST_FETCH;
                if (w_is_halt) begin
                    w_state_nxt = ST_HALT;
                end else if (w_uses_mem) begin
                    w_state_nxt = ST_MEM;
                end else if (w_writes_rd) begin
                    w_state_nxt = ST_WB;
                end
                if (w_op == OP_CMP) begin
                    w_cmp_flag_nxt = alu_compare;
                end
                if (w_is_jump || (w_is_branch && r_cmp_flag)) begin
                    w_pc_nxt = PC_W'(r_ir[IMM_MSB:IMM_LSB]);
                end
            end
            ST_MEM: begin
                // Operand select stays put so the computed address is stable for the access.
                alu_src     = 1'b1;
                alu_opcode  = w_op;
                alu_b_sel   = 1'b1;
                dmem_re     = w_is_load;
                dmem_we     = w_is_store;
                w_state_nxt = w_is_load ? ST_WB : ST_FETCH;
            end
            ST_WB: begin
                alu_src     = 1'b1;
                alu_opcode  = w_uses_alu ? w_op : 4'h0;
                alu_b_sel   = w_uses_mem;
                rf_we       = 1'b1;
                rf_wsel     = w_is_load;
                w_state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Directed program walk through the sequencer: ALU op, LOAD, CMP/BEQ both ways,
// STORE, JMP with PC wrap, asynchronous reset mid-LOAD, then HALT.
module tb_alu_ctrl_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [3:0]  alu_opcode;
    logic        alu_src;
    logic        alu_compare;
    logic        alu_b_sel;
    logic [7:0]  imm;
    logic [1:0]  rf_ra1;
    logic [1:0]  rf_ra2;
    logic [1:0]  rf_wa;
    logic        rf_we;
    logic        rf_wsel;
    logic        dmem_re;
    logic        dmem_we;
    logic        halted;

    logic [15:0] mem [256];
    logic [10:0] w_ctl;
    int          n_checks;
    int          n_errors;

    alu_ctrl_sequencer #(.PC_W(8), .INSTR_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .alu_opcode  (alu_opcode),
        .alu_src     (alu_src),
        .alu_compare (alu_compare),
        .alu_b_sel   (alu_b_sel),
        .imm         (imm),
        .rf_ra1      (rf_ra1),
        .rf_ra2      (rf_ra2),
        .rf_wa       (rf_wa),
        .rf_we       (rf_we),
        .rf_wsel     (rf_wsel),
        .dmem_re     (dmem_re),
        .dmem_we     (dmem_we),
        .halted      (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) imem_data <= mem[imem_addr];

    assign w_ctl = {alu_src, alu_opcode, alu_b_sel, rf_we, rf_wsel, dmem_re, dmem_we, halted};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] c(input logic src, input logic [3:0] opc, input logic bsel,
                                      input logic we, input logic wsel, input logic re,
                                      input logic dwe, input logic hlt);
        return {src, opc, bsel, we, wsel, re, dwe, hlt};
    endfunction

    task automatic fetch(input string tag, input logic [7:0] pc);
        check({tag, " addr"}, 32'(imem_addr), 32'(pc));
        check({tag, " ctl"}, 32'(w_ctl), 32'(0));
        @(negedge clk);
    endtask

    task automatic cyc(input string tag, input logic [10:0] exp);
        check(tag, 32'(w_ctl), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        alu_compare = 1'b0;
        imem_data   = 16'h0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000;
        mem[8'h00] = 16'h0600;
        mem[8'h01] = 16'h6910;
        mem[8'h02] = 16'h5000;
        mem[8'h03] = 16'h8042;
        mem[8'h42] = 16'h5000;
        mem[8'h43] = 16'h8042;
        mem[8'h44] = 16'h7504;
        mem[8'h45] = 16'h90FF;
        mem[8'hFF] = 16'hA000;

        repeat (3) @(negedge clk);
        check("rst addr", 32'(imem_addr), 32'(0));
        check("rst ctl", 32'(w_ctl), 32'(0));
        rst_n = 1'b1;

        // ADD r1,r2,r0
        fetch("add f", 8'h00);
        cyc("add d", 11'(0));
        check("add ra1", 32'(rf_ra1), 32'(2));
        check("add ra2", 32'(rf_ra2), 32'(0));
        cyc("add e", c(1, 4'h0, 0, 0, 0, 0, 0, 0));
        check("add wa", 32'(rf_wa), 32'(1));
        cyc("add w", c(1, 4'h0, 0, 1, 0, 0, 0, 0));

        // LOAD r2,[r1+0x10]
        fetch("ld f", 8'h01);
        cyc("ld d", 11'(0));
        check("ld imm", 32'(imm), 32'h10);
        check("ld ra1", 32'(rf_ra1), 32'(1));
        cyc("ld e", c(1, 4'h6, 1, 0, 0, 0, 0, 0));
        cyc("ld m", c(1, 4'h6, 1, 0, 0, 1, 0, 0));
        check("ld wa", 32'(rf_wa), 32'(2));
        cyc("ld w", c(1, 4'h6, 1, 1, 1, 0, 0, 0));

        // CMP true then BEQ taken; alu_compare low during BEQ must not matter
        fetch("cmp1 f", 8'h02);
        alu_compare = 1'b1;
        cyc("cmp1 d", 11'(0));
        cyc("cmp1 e", c(1, 4'h5, 0, 0, 0, 0, 0, 0));
        alu_compare = 1'b0;
        fetch("beq1 f", 8'h03);
        cyc("beq1 d", 11'(0));
        cyc("beq1 e", c(1, 4'h0, 0, 0, 0, 0, 0, 0));

        // CMP false then BEQ not taken; alu_compare high during BEQ must not matter
        fetch("beq1 tgt", 8'h42);
        cyc("cmp2 d", 11'(0));
        cyc("cmp2 e", c(1, 4'h5, 0, 0, 0, 0, 0, 0));
        alu_compare = 1'b1;
        fetch("beq2 f", 8'h43);
        cyc("beq2 d", 11'(0));
        cyc("beq2 e", c(1, 4'h0, 0, 0, 0, 0, 0, 0));
        alu_compare = 1'b0;

        // STORE: address reg rs=1, data reg rd=1 (rt field is 0)
        fetch("beq2 fall", 8'h44);
        cyc("st d", 11'(0));
        check("st ra1", 32'(rf_ra1), 32'(1));
        check("st ra2", 32'(rf_ra2), 32'(1));
        cyc("st e", c(1, 4'h7, 1, 0, 0, 0, 0, 0));
        cyc("st m", c(1, 4'h7, 1, 0, 0, 0, 1, 0));

        // JMP 0xFF, NOP at 0xFF wraps the PC to 0
        fetch("jmp f", 8'h45);
        mem[8'h00] = 16'h5000;
        cyc("jmp d", 11'(0));
        cyc("jmp e", c(1, 4'h0, 0, 0, 0, 0, 0, 0));
        fetch("jmp tgt", 8'hFF);
        cyc("nop d", 11'(0));
        cyc("nop e", c(1, 4'h0, 0, 0, 0, 0, 0, 0));

        // CMP true sets the flag, then reset during the LOAD memory cycle
        fetch("wrap f", 8'h00);
        alu_compare = 1'b1;
        cyc("cmp3 d", 11'(0));
        cyc("cmp3 e", c(1, 4'h5, 0, 0, 0, 0, 0, 0));
        alu_compare = 1'b0;
        fetch("ld2 f", 8'h01);
        cyc("ld2 d", 11'(0));
        cyc("ld2 e", c(1, 4'h6, 1, 0, 0, 0, 0, 0));
        check("ld2 m re", 32'(dmem_re), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("arst re", 32'(dmem_re), 32'(0));
        check("arst ctl", 32'(w_ctl), 32'(0));
        check("arst addr", 32'(imem_addr), 32'(0));
        mem[8'h00] = 16'h8077;
        mem[8'h01] = 16'hF000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // BEQ after reset falls through: the flag was cleared
        fetch("post f", 8'h00);
        cyc("beq3 d", 11'(0));
        cyc("beq3 e", c(1, 4'h0, 0, 0, 0, 0, 0, 0));
        fetch("beq3 fall", 8'h01);
        cyc("halt d", 11'(0));
        for (int i = 0; i < 20; i++) begin
            check("halt addr", 32'(imem_addr), 32'(2));
            cyc("halt ctl", c(0, 4'h0, 0, 0, 0, 0, 0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
